// File: rtl/sabr_udiv_79ns_6ns_73_seq.sv
// Sequential restoring radix-2 unsigned divider: quotient (low dout_WIDTH bits) and remainder.
// Latency: din0_WIDTH ce-cycles after accept (divide-by-zero goes to DONE on the accept edge).
// Backpressure: result holds in DONE until out_ready; in_ready only in IDLE; ce=0 freezes everything.
module sabr_udiv_79ns_6ns_73_seq #(
  parameter int din0_WIDTH = 79,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 73
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dbz
);

  localparam int CNT_W = $clog2(din0_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [din0_WIDTH-1:0] r_dividend;   // dividend shifts out MSB-first, quotient shifts in LSB-first
  logic [din1_WIDTH-1:0] r_divisor;
  logic [din1_WIDTH:0]   r_part;       // partial remainder
  logic [CNT_W-1:0]      r_cnt;
  logic [dout_WIDTH-1:0] r_dout;
  logic [din1_WIDTH-1:0] r_rem;
  logic                  r_ovf;
  logic                  r_dbz;

  logic                  w_accept;
  logic                  w_release;
  logic                  w_last;
  logic [din1_WIDTH:0]   w_shift;
  logic [din1_WIDTH:0]   w_div_ext;
  logic                  w_ge;
  logic [din1_WIDTH:0]   w_part_nxt;
  logic [din0_WIDTH-1:0] w_quot_nxt;

  assign w_accept  = ce & in_valid & (r_state == S_IDLE);
  assign w_release = ce & out_ready & (r_state == S_DONE);
  assign w_last    = (r_state == S_CALC) && (r_cnt == CNT_W'(1));

  // One restoring step: bring in the next dividend bit, subtract when it fits.
  // The partial MSB is always zero between steps; folding it into the compare
  // keeps the step correct even if the partial were ever one bit wider.
  assign w_shift    = {r_part[din1_WIDTH-1:0], r_dividend[din0_WIDTH-1]};
  assign w_div_ext  = {1'b0, r_divisor};
  assign w_ge       = r_part[din1_WIDTH] | (w_shift >= w_div_ext);
  assign w_part_nxt = w_ge ? (w_shift - w_div_ext) : w_shift;
  assign w_quot_nxt = {r_dividend[din0_WIDTH-2:0], w_ge};

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign dout      = r_dout;
  assign rem       = r_rem;
  assign ovf       = r_ovf;
  assign dbz       = r_dbz;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; nothing moves without ce.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept)  w_state_nxt = (din1 == '0) ? S_DONE : S_CALC;
      S_CALC: if (ce && w_last) w_state_nxt = S_DONE;
      S_DONE: if (w_release) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath, step counter and result registers; results only change on entry to DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_part     <= '0;
      r_cnt      <= '0;
      r_dout     <= '0;
      r_rem      <= '0;
      r_ovf      <= 1'b0;
      r_dbz      <= 1'b0;
    end else if (ce) begin
      if (w_accept) begin
        r_dividend <= din0;
        r_divisor  <= din1;
        r_part     <= '0;
        r_cnt      <= CNT_W'(din0_WIDTH);
        if (din1 == '0) begin
          r_dout <= '1;
          r_rem  <= din0[din1_WIDTH-1:0];
          r_ovf  <= 1'b0;
          r_dbz  <= 1'b1;
        end
      end else if (r_state == S_CALC) begin
        r_dividend <= w_quot_nxt;
        r_part     <= w_part_nxt;
        r_cnt      <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_dout <= w_quot_nxt[dout_WIDTH-1:0];
          r_rem  <= w_part_nxt[din1_WIDTH-1:0];
          r_ovf  <= |(w_quot_nxt >> dout_WIDTH);
          r_dbz  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/sabr_udiv_79ns_6ns_73_seq.md
SABR_UDIV_79NS_6NS_73_SEQ -- requirements
Module: sabr_udiv_79ns_6ns_73_seq

Interface
REQ-001 SHALL have parameter din0_WIDTH, default 79, dividend width.
REQ-002 SHALL have parameter din1_WIDTH, default 6, divisor and remainder width.
REQ-003 SHALL have parameter dout_WIDTH, default 73, quotient output width (dout_WIDTH <= din0_WIDTH).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port ce, input, 1, clock enable; low freezes all state.
REQ-007 SHALL have port in_valid, input, 1, din0/din1 valid.
REQ-008 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-009 SHALL have port din0, input, din0_WIDTH, unsigned dividend.
REQ-010 SHALL have port din1, input, din1_WIDTH, unsigned divisor.
REQ-011 SHALL have port out_valid, output, 1, result valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 SHALL have port dout, output, dout_WIDTH, quotient, low dout_WIDTH bits.
REQ-014 SHALL have port rem, output, din1_WIDTH, remainder.
REQ-015 SHALL have port ovf, output, 1, full quotient exceeds dout_WIDTH bits.
REQ-016 SHALL have port dbz, output, 1, divisor was zero.

Function
REQ-017 SHALL implement FSM states IDLE, CALC, DONE; every transition and register update requires ce=1.
REQ-018 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE (combinational decode of state).
REQ-019 SHALL accept on rising edge with ce & in_valid & in_ready: latch din0, din1, clear partial remainder (din1_WIDTH+1 bits), load step counter = din0_WIDTH.
REQ-020 SHALL, on accept with din1 != 0, go IDLE -> CALC; with din1 == 0, go IDLE -> DONE directly.
REQ-021 SHALL in CALC perform one restoring radix-2 step per ce edge: shift in next dividend MSB, subtract divisor if partial >= divisor, shift resulting quotient bit in LSB.
REQ-022 SHALL go CALC -> DONE on the ce edge performing the last (din0_WIDTH-th) step; out_valid visible after that edge (latency = din0_WIDTH ce-cycles from accept edge, excluding stalls).
REQ-023 SHALL compute quotient internally at full din0_WIDTH bits; dout = low dout_WIDTH bits; ovf=1 iff any discarded upper bit is 1.
REQ-024 SHALL on divide-by-zero output dout = all ones, rem = din0[din1_WIDTH-1:0], dbz=1, ovf=0.
REQ-025 SHALL hold dout, rem, ovf, dbz stable throughout DONE until handshake.
REQ-026 SHALL go DONE -> IDLE on ce & out_valid & out_ready; no same-edge new accept (throughput one result per din0_WIDTH+2 cycles minimum).
REQ-027 SHALL ignore in_valid outside IDLE and out_ready outside DONE.
REQ-028 SHALL freeze state, counter, datapath and outputs while ce=0, including mid-CALC; resumed result identical to unstalled result.
REQ-029 SHALL leave dout/rem/ovf/dbz holding previous result values in IDLE and CALC (not qualified without out_valid).

Reset
REQ-030 SHALL on reset=0, asynchronously, force state IDLE, counter 0, dout 0, rem 0, ovf 0, dbz 0, out_valid 0, in_ready 1 after release.
REQ-031 SHALL abort any in-progress division on reset assertion mid-CALC or mid-DONE, discarding the result.
REQ-032 SHALL accept a new operand on the first ce edge after reset release with in_valid=1.

Verification
REQ-033 SHALL test basic: din0=100, din1=7, ce=1 -> out_valid after 79 edges, dout=14, rem=2, ovf=0, dbz=0.
REQ-034 SHALL test overflow: din0=2^79-1, din1=1 -> dout=2^73-1, rem=0, ovf=1.
REQ-035 SHALL test divide-by-zero: din0=0x...2D (low 6 bits 45), din1=0 -> out_valid one edge after accept, dout all ones, rem=45, dbz=1.
REQ-036 SHALL test stall: din0=1000, din1=63, ce=0 for 10 cycles mid-CALC -> out_valid after 89 clock edges, dout=15, rem=55.
REQ-037 SHALL test backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-038 SHALL test reset mid-CALC (step 40) -> immediate out_valid=0, dout=0, in_ready=1; next 100/7 completes correctly.
